squash_arbiter: RTL and testbench

Two-client front-end controller for the worm_squasher accelerator. Arbitrates CPU inspection requests round-robin and sequences one accelerator transaction at a time: select payload, start pulse, wait for result. Returns a per-client verdict via a done/ack handshake. A watchdog forces a fail-safe "match" verdict if the accelerator never reports.

---
 rtl/squash_arbiter_if.sv | 27 ++
 rtl/squash_arbiter.sv | 141 ++++++++++++++
 tb/tb_squash_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/squash_arbiter_if.sv
// Client and accelerator handshake bundle for squash_arbiter.
// master = arbiter side, slave = clients/accelerator side.
interface squash_arbiter_if;
  logic       req0_i, req1_i;
  logic       gnt0_o, gnt1_o;
  logic       done0_o, done1_o;
  logic       match0_o, match1_o;
  logic       ack0_i, ack1_i;
  logic       acc_start_o;
  logic       acc_sel_o;
  logic       acc_busy_i;
  logic       acc_valid_i;
  logic       acc_match_i;
  logic [7:0] timeout_cnt_o;

  modport master (
    input  req0_i, req1_i, ack0_i, ack1_i, acc_busy_i, acc_valid_i, acc_match_i,
    output gnt0_o, gnt1_o, done0_o, done1_o, match0_o, match1_o,
           acc_start_o, acc_sel_o, timeout_cnt_o
  );

  modport slave (
    output req0_i, req1_i, ack0_i, ack1_i, acc_busy_i, acc_valid_i, acc_match_i,
    input  gnt0_o, gnt1_o, done0_o, done1_o, match0_o, match1_o,
           acc_start_o, acc_sel_o, timeout_cnt_o
  );
endinterface

// File: rtl/squash_arbiter.sv
// Two-client round-robin front end for the worm_squasher accelerator,
// one transaction in flight, with a watchdog that forces a "match" verdict.

// Per-client verdict holder: done/match flags and eligibility.
module squash_client (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req,
  input  logic ack,
  input  logic cap,
  input  logic cap_match,
  output logic done,
  output logic match,
  output logic elig
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done  <= 1'b0;
      match <= 1'b0;
    end else if (cap) begin
      done  <= 1'b1;
      match <= cap_match;
    end else if (ack && done) begin
      done  <= 1'b0;
    end
  end

  // A client with an unacked verdict cannot be granted again.
  assign elig = req & ~done;
endmodule

module squash_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic              clk_i,
  input logic              rst_ni,
  squash_arbiter_if.master bus
);
  localparam int NUM_CLI = 2;
  localparam int CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic [NUM_CLI-1:0]  req, ack, done, match, elig, cap, gnt;
  logic                cap_match, start, win;

  assign req = {bus.req1_i, bus.req0_i};
  assign ack = {bus.ack1_i, bus.ack0_i};

  for (genvar g = 0; g < NUM_CLI; g++) begin : g_cli
    squash_client u_cli (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req       (req[g]),
      .ack       (ack[g]),
      .cap       (cap[g]),
      .cap_match (cap_match),
      .done      (done[g]),
      .match     (match[g]),
      .elig      (elig[g])
    );
  end

  // On a tie the client that was not served last wins.
  assign win = (&elig) ? ~last_q : elig[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    cap       = '0;
    cap_match = 1'b0;
    start     = 1'b0;
    gnt       = '0;
    case (state_q)
      IDLE: begin
        if (!bus.acc_busy_i && |elig) begin
          sel_d   = win;
          state_d = START;
        end
      end
      START: begin
        start      = 1'b1;
        gnt[sel_q] = 1'b1;
        last_d     = sel_q;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.acc_valid_i) begin
          cap[sel_q] = 1'b1;
          cap_match  = bus.acc_match_i;
          state_d    = IDLE;
        end else if (cnt_q == TLAST) begin
          // Fail safe: an unanswered request is treated as a worm.
          cap[sel_q] = 1'b1;
          cap_match  = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt0_o        = gnt[0];
  assign bus.gnt1_o        = gnt[1];
  assign bus.done0_o       = done[0];
  assign bus.done1_o       = done[1];
  assign bus.match0_o      = match[0];
  assign bus.match1_o      = match[1];
  assign bus.acc_start_o   = start;
  assign bus.acc_sel_o     = sel_q;
  assign bus.timeout_cnt_o = tcnt_q;
endmodule

// File: tb/tb_squash_arbiter.sv
// Directed scoreboard bench for squash_arbiter: grants and verdicts are
// queued by the stimulus and checked by an independent monitor.
module tb_squash_arbiter;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  squash_arbiter_if bus ();
  squash_arbiter #(.TIMEOUT(15)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus.master));

  typedef struct packed {logic cli; logic m; logic [7:0] t;} done_t;

  int    total = 0;
  int    bad   = 0;
  logic  exp_gnt_q[$];
  done_t exp_done_q[$];
  int    resp_lat   = -1;
  logic  resp_match = 1'b0;
  logic [1:0] auto_ack = 2'b00;

  function automatic done_t mk(input logic c, input logic m, input int t);
    done_t d;
    d.cli = c; d.m = m; d.t = 8'(t);
    return d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Accelerator model: valid resp_lat cycles after the start pulse.
  initial begin
    bus.acc_valid_i = 1'b0;
    bus.acc_match_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_ni && bus.acc_start_o === 1'b1 && resp_lat >= 0) begin
        repeat (resp_lat) @(negedge clk);
        bus.acc_valid_i = 1'b1;
        bus.acc_match_i = resp_match;
        @(negedge clk);
        bus.acc_valid_i = 1'b0;
      end
    end
  end

  // Client ack model.
  initial begin
    bus.ack0_i = 1'b0;
    bus.ack1_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ack0_i = auto_ack[0] & bus.done0_o;
      bus.ack1_i = auto_ack[1] & bus.done1_o;
    end
  end

  // Monitor: compares every grant and every new verdict against the queues.
  initial begin
    logic [1:0] dprev, dnow;
    logic       c;
    done_t      e;
    dprev = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        dprev = 2'b00;
      end else begin
        if (bus.gnt0_o || bus.gnt1_o) begin
          if (exp_gnt_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexp_gnt: got gnt=%b want none", {bus.gnt1_o, bus.gnt0_o});
          end else begin
            c = exp_gnt_q.pop_front();
            chk("gnt_cli", int'({bus.gnt1_o, bus.gnt0_o}), c ? 2 : 1);
            chk("gnt_sel", int'(bus.acc_sel_o), int'(c));
            chk("gnt_start", int'(bus.acc_start_o), 1);
          end
        end
        dnow = {bus.done1_o, bus.done0_o};
        for (int k = 0; k < 2; k++) begin
          if (dnow[k] && !dprev[k]) begin
            if (exp_done_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexp_done: got client %0d want none", k);
            end else begin
              e = exp_done_q.pop_front();
              chk("done_cli", k, int'(e.cli));
              chk("done_match", int'(k ? bus.match1_o : bus.match0_o), int'(e.m));
              chk("done_tcnt", int'(bus.timeout_cnt_o), int'(e.t));
            end
          end
        end
        dprev = dnow;
      end
    end
  end

  task automatic wait_gnt(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.gnt0_o || bus.gnt1_o) && n < maxc);
    if (!(bus.gnt0_o || bus.gnt1_o)) begin
      total++; bad++;
      $display("FAIL gnt_timeout: got no grant in %0d cycles want grant", maxc);
    end
  endtask

  task automatic wait_done(input int c, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(c ? bus.done1_o : bus.done0_o) && n < maxc);
    if (!(c ? bus.done1_o : bus.done0_o)) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done%0d in %0d cycles want done", c, maxc);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus.req0_i = 1'b0; bus.req1_i = 1'b0; bus.acc_busy_i = 1'b0;
    resp_lat = -1; auto_ack = 2'b00;
    exp_gnt_q.delete(); exp_done_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, g;
    rst_ni = 1'b0;
    bus.req0_i = 1'b0; bus.req1_i = 1'b0; bus.acc_busy_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt_done", int'({bus.gnt1_o, bus.gnt0_o, bus.done1_o, bus.done0_o}), 0);
    chk("rst_match_start_sel", int'({bus.match1_o, bus.match0_o, bus.acc_start_o, bus.acc_sel_o}), 0);
    chk("rst_tcnt", int'(bus.timeout_cnt_o), 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Single client, valid two cycles after start.
    exp_gnt_q.push_back(1'b0);
    exp_done_q.push_back(mk(1'b0, 1'b1, 0));
    resp_lat = 2; resp_match = 1'b1;
    bus.req0_i = 1'b1;
    wait_gnt(5, n);
    chk("t1_gnt_lat", n, 1);
    bus.req0_i = 1'b0;
    wait_done(0, 10, n);
    chk("t1_done_lat", n, 3);
    chk("t1_sel", int'(bus.acc_sel_o), 0);
    auto_ack[0] = 1'b1;
    @(negedge clk);
    chk("t1_done_held", int'(bus.done0_o), 1);
    @(negedge clk);
    chk("t1_done_clr", int'(bus.done0_o), 0);
    chk("t1_match_hold", int'(bus.match0_o), 1);
    auto_ack = 2'b00;

    // Tie with immediate acks: 0,1,0,1 from reset.
    do_reset();
    resp_lat = 1; resp_match = 1'b0; auto_ack = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_gnt_q.push_back(i[0]);
      exp_done_q.push_back(mk(i[0], 1'b0, 0));
    end
    bus.req0_i = 1'b1; bus.req1_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(12, n);
      if (i == 3) begin bus.req0_i = 1'b0; bus.req1_i = 1'b0; end
    end
    wait_done(1, 10, n);
    repeat (3) @(negedge clk);

    // Client 0 holds its verdict, so client 1 keeps winning until ack0.
    resp_match = 1'b1; auto_ack = 2'b10;
    exp_gnt_q.push_back(1'b0); exp_done_q.push_back(mk(1'b0, 1'b1, 0));
    for (int i = 0; i < 3; i++) begin
      exp_gnt_q.push_back(1'b1); exp_done_q.push_back(mk(1'b1, 1'b1, 0));
    end
    exp_gnt_q.push_back(1'b0); exp_done_q.push_back(mk(1'b0, 1'b1, 0));
    bus.req0_i = 1'b1; bus.req1_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(20, n);
      if (i == 3) auto_ack[0] = 1'b1;
      if (i == 4) begin bus.req0_i = 1'b0; bus.req1_i = 1'b0; end
    end
    wait_done(0, 10, n);
    repeat (3) @(negedge clk);
    auto_ack = 2'b00;

    // Watchdog: no valid ever; then saturate the event counter.
    do_reset();
    exp_gnt_q.push_back(1'b1); exp_done_q.push_back(mk(1'b1, 1'b1, 1));
    bus.req1_i = 1'b1;
    wait_gnt(5, n);
    bus.req1_i = 1'b0;
    wait_done(1, 30, n);
    chk("t4_wd_lat", n, 16);
    chk("t4_tcnt1", int'(bus.timeout_cnt_o), 1);
    for (int k = 2; k <= 256; k++) begin
      exp_gnt_q.push_back(1'b1);
      exp_done_q.push_back(mk(1'b1, 1'b1, (k > 255) ? 255 : k));
    end
    auto_ack[1] = 1'b1;
    bus.req1_i = 1'b1;
    for (int k = 2; k <= 256; k++) begin
      wait_gnt(40, n);
      if (k == 256) bus.req1_i = 1'b0;
    end
    wait_done(1, 30, n);
    chk("t4_tcnt_sat", int'(bus.timeout_cnt_o), 255);
    repeat (3) @(negedge clk);
    auto_ack = 2'b00;

    // Valid arriving on the timeout cycle wins over the watchdog.
    do_reset();
    exp_gnt_q.push_back(1'b0); exp_done_q.push_back(mk(1'b0, 1'b1, 1));
    exp_gnt_q.push_back(1'b0); exp_done_q.push_back(mk(1'b0, 1'b0, 1));
    bus.req0_i = 1'b1;
    wait_gnt(5, n);
    bus.req0_i = 1'b0;
    wait_done(0, 30, n);
    auto_ack[0] = 1'b1;
    resp_lat = 15; resp_match = 1'b0;
    bus.req0_i = 1'b1;
    wait_gnt(10, n);
    bus.req0_i = 1'b0;
    wait_done(0, 30, n);
    chk("t5_done_lat", n, 16);
    chk("t5_match", int'(bus.match0_o), 0);
    chk("t5_tcnt", int'(bus.timeout_cnt_o), 1);
    repeat (3) @(negedge clk);
    auto_ack = 2'b00;

    // Busy stall, then async reset in WAIT.
    resp_lat = -1;
    bus.acc_busy_i = 1'b1; bus.req1_i = 1'b1;
    g = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt0_o || bus.gnt1_o) g++;
    end
    chk("t6_busy_nogrant", g, 0);
    exp_gnt_q.push_back(1'b1);
    bus.acc_busy_i = 1'b0;
    wait_gnt(5, n);
    chk("t6_unstall_lat", n, 1);
    bus.req1_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_outs", int'({bus.gnt1_o, bus.gnt0_o, bus.done1_o, bus.done0_o, bus.acc_start_o}), 0);
    chk("t6_rst_tcnt", int'(bus.timeout_cnt_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    resp_lat = 1; resp_match = 1'b1;
    exp_gnt_q.push_back(1'b0); exp_done_q.push_back(mk(1'b0, 1'b1, 0));
    bus.req0_i = 1'b1; bus.req1_i = 1'b1;
    wait_gnt(5, n);
    chk("t6_tie_after_rst", int'(bus.acc_sel_o), 0);
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    wait_done(0, 10, n);
    repeat (2) @(negedge clk);

    chk("gnt_q_empty", exp_gnt_q.size(), 0);
    chk("done_q_empty", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
